// File: rtl/carry_save_resolver.sv
// rtl/carry_save_resolver.sv - sequential carry-propagate resolver for two carry-save rows
// Optional early completion on zero upper operands: define CSR_EARLY_DONE_EN.
module carry_save_resolver #(
    parameter int WIDTH = 10,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] r1,
    input  logic [WIDTH-1:0] r2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
);

    localparam int N     = WIDTH / CHUNK;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    generate
        if (WIDTH % CHUNK != 0) begin : g_bad_chunk
            $error("carry_save_resolver: CHUNK must divide WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_op1;
    logic [WIDTH-1:0]   r_op2;
    logic [WIDTH-1:0]   r_sum;
    logic [IDX_W-1:0]   r_idx;
    logic               r_carry;
    logic               r_carry_out;
    logic               r_in_ready;
    logic               r_out_valid;

    logic [CHUNK:0]     w_chunk;
    logic [WIDTH-1:0]   w_op1_next;
    logic [WIDTH-1:0]   w_op2_next;
    logic               w_finish;

    // Operands shift right each cycle so the current chunk is always at the bottom.
    assign w_chunk    = {1'b0, r_op1[CHUNK-1:0]} + {1'b0, r_op2[CHUNK-1:0]}
                      + {{CHUNK{1'b0}}, r_carry};
    assign w_op1_next = r_op1 >> CHUNK;
    assign w_op2_next = r_op2 >> CHUNK;

`ifdef CSR_EARLY_DONE_EN
    logic w_early;
    assign w_early  = (w_op1_next == '0) && (w_op2_next == '0) && !w_chunk[CHUNK];
    assign w_finish = (r_idx == LAST_IDX) || w_early;
`else
    assign w_finish = (r_idx == LAST_IDX);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_op1       <= '0;
            r_op2       <= '0;
            r_sum       <= '0;
            r_idx       <= '0;
            r_carry     <= 1'b0;
            r_carry_out <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_op1       <= r1;
                        r_op2       <= r2;
                        // Clearing sum here makes early completion need no masking.
                        r_sum       <= '0;
                        r_idx       <= '0;
                        r_carry     <= 1'b0;
                        r_carry_out <= 1'b0;
                        r_in_ready  <= 1'b0;
                        r_state     <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    r_op1                        <= w_op1_next;
                    r_op2                        <= w_op2_next;
                    r_sum[r_idx*CHUNK +: CHUNK]  <= w_chunk[CHUNK-1:0];
                    r_carry                      <= w_chunk[CHUNK];
                    r_idx                        <= r_idx + 1'b1;
                    if (w_finish) begin
                        r_carry_out <= w_chunk[CHUNK];
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign carry_out = r_carry_out;

endmodule

// File: tb/tb_carry_save_resolver.sv
// tb/tb_carry_save_resolver.sv - directed and random checks of carry_save_resolver
// Expected latency follows CSR_EARLY_DONE_EN when that macro is defined for the bench too.
module tb_carry_save_resolver;

    localparam int WIDTH = 10;
    localparam int CHUNK = 2;
    localparam int N     = WIDTH / CHUNK;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] r1 = '0;
    logic [WIDTH-1:0] r2 = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] sum;
    logic             carry_out;

    int tests = 0;
    int fails = 0;

    carry_save_resolver #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .r1        (r1),
        .r2        (r2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carry_out (carry_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Cycles from acceptance to out_valid, derived from plain integer arithmetic.
    function automatic int exp_lat(input int a, input int b);
`ifdef CSR_EARLY_DONE_EN
        for (int k = 1; k <= N; k++) begin
            int lim = k * CHUNK;
            int m   = (1 << lim) - 1;
            if ((a >> lim) == 0 && (b >> lim) == 0 && (((a & m) + (b & m)) >> lim) == 0)
                return k;
        end
`endif
        return N;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Present a pair and return once it has been accepted (just after the accepting edge).
    task automatic send(input int a, input int b);
        int guard = 0;
        r1 = WIDTH'(a);
        r2 = WIDTH'(b);
        in_valid = 1'b1;
        while (!in_ready && guard < 50) begin
            next_cycle();
            guard++;
        end
        chk("accept_ready", {31'd0, in_ready}, 32'd1);
        next_cycle();
        in_valid = 1'b0;
    endtask

    task automatic wait_result(output int cycles);
        cycles = 0;
        while (!out_valid && cycles < 40) begin
            next_cycle();
            cycles++;
        end
    endtask

    task automatic run_op(input string tag, input int a, input int b, input bit full);
        int cyc;
        int total = a + b;
        send(a, b);
        wait_result(cyc);
        chk({tag, "_lat"}, cyc, exp_lat(a, b));
        chk({tag, "_sum"}, {22'd0, sum}, total % (1 << WIDTH));
        chk({tag, "_cout"}, {31'd0, carry_out}, (total >> WIDTH) & 1);
        if (full) begin
            chk({tag, "_inrdy_busy"}, {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        next_cycle();
        if (full) begin
            chk({tag, "_ovld_drop"}, {31'd0, out_valid}, 32'd0);
            chk({tag, "_inrdy_back"}, {31'd0, in_ready}, 32'd1);
        end
    endtask

    initial begin
        int cyc;
        int seen;
        // Reset state
        next_cycle();
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_sum", {22'd0, sum}, 32'd0);
        chk("rst_cout", {31'd0, carry_out}, 32'd0);
        rst_n = 1'b1;
        next_cycle();

        run_op("r20_15", 20, 15, 1'b1);
        run_op("r512_449", 512, 449, 1'b1);
        run_op("r0_0", 0, 0, 1'b1);
        run_op("ripple", 'h3FF, 'h001, 1'b1);

        // Backpressure: result must hold while a competing pair is offered.
        out_ready = 1'b0;
        send(100, 23);
        wait_result(cyc);
        chk("bp_lat", cyc, exp_lat(100, 23));
        r1 = 10'd1;
        r2 = 10'd1;
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("bp_sum_hold", {22'd0, sum}, 32'd123);
            chk("bp_ovld_hold", {31'd0, out_valid}, 32'd1);
            chk("bp_inrdy_low", {31'd0, in_ready}, 32'd0);
            next_cycle();
        end
        chk("bp_sum_final", {22'd0, sum}, 32'd123);
        out_ready = 1'b1;
        next_cycle();
        chk("bp_idle_ready", {31'd0, in_ready}, 32'd1);
        next_cycle();
        in_valid = 1'b0;
        wait_result(cyc);
        chk("bp_second_lat", cyc, exp_lat(1, 1));
        chk("bp_second_sum", {22'd0, sum}, 32'd2);
        next_cycle();

        // Reset in the middle of BUSY discards the operation.
        send(300, 300);
        next_cycle();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_sum", {22'd0, sum}, 32'd0);
        chk("mid_rst_cout", {31'd0, carry_out}, 32'd0);
        next_cycle();
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            next_cycle();
            if (out_valid) seen++;
        end
        chk("mid_rst_no_result", seen, 32'd0);
        run_op("after_rst", 7, 8, 1'b1);

        run_op("early_3_0", 3, 0, 1'b1);

        // Random Wallace-like row pairs whose true sum is a 5x5 product.
        for (int i = 0; i < 200; i++) begin
            int a = int'($urandom_range(0, 31));
            int b = int'($urandom_range(0, 31));
            int p = a * b;
            int x = int'($urandom_range(0, p));
            run_op("rand", p - x, x, 1'b0);
            chk("rand_product", {22'd0, sum}, p);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
